// File: rtl/dram_io_pkg.sv
// dram_io_pkg: shared encodings for the DRAM read/write command sequencer.
//   - IO_MODEL codes driven towards the DRAM controller
//   - command mode encodings for the sequencer's mode input
//   - sequencer FSM state enum
//   - pat_word(): test pattern word k of a burst
package dram_io_pkg;

  typedef enum logic [1:0] {
    IOM_IDLE = 2'b00,
    IOM_WR   = 2'b01,
    IOM_RD   = 2'b10
  } io_model_e;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_WR    = 2'b01;
  localparam logic [1:0] MODE_RD    = 2'b10;
  localparam logic [1:0] MODE_WR_RD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_FINISH
  } seq_state_e;

  // Word k of a burst is seed + k, wrapping at 16 bits.
  function automatic logic [15:0] pat_word(input logic [15:0] seed, input logic [15:0] k);
    return seed + k;
  endfunction

endpackage

// File: rtl/dram_rw_watchdog.sv
// dram_rw_watchdog: loadable down-counter guarding one controller operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : pulse in the IO_EN cycle; arms the counter
//   enable     : high while waiting for the controller's done
//   expired    : high in the last allowed waiting cycle
// The load cycle itself counts as the first elapsed cycle, so expired is
// raised TIMEOUT_CYC-1 waiting cycles after load and the sequencer's
// registered timeout flag lands exactly TIMEOUT_CYC cycles after IO_EN.
module dram_rw_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CW'(TIMEOUT_CYC - 1);
    end else if (enable && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign expired = enable && !load && (r_cnt <= CW'(1));

endmodule

// File: rtl/dram_rw_sequencer.sv
// dram_rw_sequencer: command-issue stage in front of the DRAM write/read
// controller. One start runs a burst of num_words words (write, read, or
// write-then-read), checks read-back data against the seed+k pattern and
// guards every controller operation with a watchdog.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start/mode/num_words/seed : command; sampled only in IDLE
//   busy, done            : command in progress / one-cycle end pulse
//   err_cnt               : saturating read-mismatch count of last command
//   timeout, proto_err    : sticky flags, cleared on the next accepted start
//   IO_EN/IO_MODEL/DRAM16_data : request towards the controller
//   WT_DONE/RD_DONE/RD_DATA    : completion from the controller
module dram_rw_sequencer
  import dram_io_pkg::*;
#(
  parameter int NW_W        = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [NW_W-1:0] num_words,
  input  logic [15:0]     seed,
  output logic            busy,
  output logic            done,
  output logic [NW_W-1:0] err_cnt,
  output logic            timeout,
  output logic            proto_err,
  output logic            IO_EN,
  output logic [1:0]      IO_MODEL,
  output logic [16:1]     DRAM16_data,
  input  logic            WT_DONE,
  input  logic            RD_DONE,
  input  logic [16:1]     RD_DATA
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  seq_state_e      r_state;
  logic [1:0]      r_mode;
  logic [NW_W-1:0] r_nw;
  logic [15:0]     r_seed;
  logic [NW_W-1:0] r_k;
  logic            r_phase_rd;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_fin_pend;
  logic            r_busy;
  logic            r_done;
  logic [NW_W-1:0] r_err;
  logic            r_tmo;
  logic            r_perr;
  logic            r_io_en;
  logic [1:0]      r_io_model;
  logic [15:0]     r_data;

  logic            w_exp_done;
  logic            w_unexp_done;
  logic            w_done_any;
  logic [NW_W-1:0] w_k_next;
  logic            w_last;
  logic            w_more;
  logic            w_phase_nxt;
  logic [NW_W-1:0] w_k_after;
  logic [15:0]     w_pattern;
  logic            w_expired;

  assign w_exp_done   = r_phase_rd ? RD_DONE : WT_DONE;
  assign w_unexp_done = r_phase_rd ? WT_DONE : RD_DONE;
  assign w_done_any   = WT_DONE | RD_DONE;
  assign w_k_next     = r_k + NW_W'(1);
  assign w_last       = (w_k_next == r_nw);
  // Another word follows unless the last word of the final burst just completed.
  assign w_more       = !w_last || (!r_phase_rd && r_mode == MODE_WR_RD);
  // Only meaningful when w_more: finishing the write burst flips to read.
  assign w_phase_nxt  = r_phase_rd | w_last;
  assign w_k_after    = w_last ? '0 : w_k_next;
  assign w_pattern    = pat_word(r_seed, 16'(r_k));

  dram_rw_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (r_state == S_ISSUE),
    .enable (r_state == S_WAIT),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= MODE_NOP;
      r_nw       <= '0;
      r_seed     <= '0;
      r_k        <= '0;
      r_phase_rd <= 1'b0;
      r_gap_cnt  <= '0;
      r_fin_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
      r_tmo      <= 1'b0;
      r_perr     <= 1'b0;
      r_io_en    <= 1'b0;
      r_io_model <= IOM_IDLE;
      r_data     <= '0;
    end else begin
      r_io_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_done_any) r_perr <= 1'b1;
          if (start) begin
            r_err  <= '0;
            r_tmo  <= 1'b0;
            // A stray done in the start cycle still counts against this command.
            r_perr <= w_done_any;
            if (mode != MODE_NOP && num_words != '0) begin
              r_mode     <= mode;
              r_nw       <= num_words;
              r_seed     <= seed;
              r_k        <= '0;
              r_phase_rd <= (mode == MODE_RD);
              r_busy     <= 1'b1;
              r_io_en    <= 1'b1;
              r_io_model <= (mode == MODE_RD) ? IOM_RD : IOM_WR;
              r_data     <= seed;
              r_state    <= S_ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end
          end
        end

        S_ISSUE: begin
          if (w_done_any) r_perr <= 1'b1;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (w_unexp_done) r_perr <= 1'b1;
          if (w_exp_done) begin
            if (r_phase_rd && RD_DATA != w_pattern && r_err != '1)
              r_err <= r_err + NW_W'(1);
            r_k        <= w_k_after;
            r_phase_rd <= w_phase_nxt;
            if (GAP_CYC == 0) begin
              if (w_more) begin
                r_io_en    <= 1'b1;
                r_io_model <= w_phase_nxt ? IOM_RD : IOM_WR;
                r_data     <= pat_word(r_seed, 16'(w_k_after));
                r_state    <= S_ISSUE;
              end else begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_io_model <= IOM_IDLE;
                r_state    <= S_FINISH;
              end
            end else begin
              r_fin_pend <= !w_more;
              r_gap_cnt  <= GW'(GAP_CYC - 1);
              r_io_model <= IOM_IDLE;
              r_state    <= S_GAP;
            end
          end else if (w_expired) begin
            r_tmo      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_io_model <= IOM_IDLE;
            r_state    <= S_FINISH;
          end
        end

        S_GAP: begin
          if (w_done_any) r_perr <= 1'b1;
          if (r_gap_cnt == '0) begin
            if (r_fin_pend) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_io_en    <= 1'b1;
              r_io_model <= r_phase_rd ? IOM_RD : IOM_WR;
              r_data     <= w_pattern;
              r_state    <= S_ISSUE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end

        S_FINISH: begin
          if (w_done_any) r_perr <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err_cnt     = r_err;
  assign timeout     = r_tmo;
  assign proto_err   = r_perr;
  assign IO_EN       = r_io_en;
  assign IO_MODEL    = r_io_model;
  assign DRAM16_data = r_data;

endmodule

// File: tb/tb_dram_rw_sequencer.sv
module tb_dram_rw_sequencer;

  localparam int NW_W = 8;
  localparam int TMO  = 1024;
  localparam int GAP  = 2;

  logic            clk, rst_n, start;
  logic [1:0]      mode;
  logic [NW_W-1:0] num_words;
  logic [15:0]     seed;
  logic            busy, done, timeout, proto_err, IO_EN;
  logic [NW_W-1:0] err_cnt;
  logic [1:0]      IO_MODEL;
  logic [16:1]     DRAM16_data, RD_DATA;
  logic            WT_DONE, RD_DONE;

  dram_rw_sequencer #(.NW_W(NW_W), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_words(num_words),
    .seed(seed), .busy(busy), .done(done), .err_cnt(err_cnt), .timeout(timeout),
    .proto_err(proto_err), .IO_EN(IO_EN), .IO_MODEL(IO_MODEL),
    .DRAM16_data(DRAM16_data), .WT_DONE(WT_DONE), .RD_DONE(RD_DONE), .RD_DATA(RD_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Observed IO_EN requests of the last command.
  int          ops_cyc[$];
  logic [1:0]  ops_mdl[$];
  logic [15:0] ops_dat[$];

  int          res_ndone, res_done_cyc, res_bad_busy, res_bad_hold;
  logic [7:0]  res_err;
  logic        res_tmo, res_perr;
  bit          res_aborted;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  nw;
    logic [15:0] seed;
    int          lat;
    logic [7:0]  bad;
    int          exp_ops;
    int          exp_err;
    logic [15:0] exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Runs one command against a controller model. The controller answers each
  // IO_EN after lat cycles (lat=0: never). Writes go to a loopback memory;
  // reads return the loopback word (or the pattern when nothing was written),
  // XORed with 0088 for read index k when bad[k] is set.
  task automatic run_cmd(input logic [1:0] m, input logic [7:0] n, input logic [15:0] s,
                         input int lat, input logic [7:0] bad, input bit inj,
                         input int abort_after, input int budget);
    int cd, rd_k, words;
    bit injected, real_cmd;
    logic [15:0] wr_mem[$];
    logic [15:0] pend_d, v;
    logic [1:0]  pend_m;
    ops_cyc.delete(); ops_mdl.delete(); ops_dat.delete();
    res_ndone = 0; res_done_cyc = -1; res_bad_busy = 0; res_bad_hold = 0;
    res_err = '0; res_tmo = 1'b0; res_perr = 1'b0; res_aborted = 1'b0;
    cd = 0; rd_k = 0; words = 0; injected = 1'b0; pend_d = '0; pend_m = '0;
    real_cmd = (m != 2'b00) && (n != 8'd0);
    @(negedge clk);
    start = 1'b1; mode = m; num_words = n; seed = s;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      WT_DONE = 1'b0; RD_DONE = 1'b0;
      if (abort_after > 0 && words >= abort_after) begin
        res_aborted = 1'b1;
        break;
      end
      if (done) begin
        res_ndone++;
        if (res_done_cyc < 0) begin
          res_done_cyc = cyc; res_err = err_cnt; res_tmo = timeout; res_perr = proto_err;
        end
      end
      if (busy != (real_cmd && res_done_cyc < 0)) res_bad_busy++;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (DRAM16_data != pend_d) res_bad_hold++;
          if (pend_m == 2'b01) begin
            WT_DONE = 1'b1;
            wr_mem.push_back(pend_d);
          end else begin
            v = (rd_k < wr_mem.size()) ? wr_mem[rd_k] : s + 16'(rd_k);
            if (rd_k < 8 && bad[rd_k]) v = v ^ 16'h0088;
            RD_DATA = v;
            RD_DONE = 1'b1;
            rd_k++;
          end
          words++;
        end else if (inj && !injected && pend_m == 2'b01) begin
          RD_DONE = 1'b1;
          injected = 1'b1;
        end
      end
      if (IO_EN) begin
        ops_cyc.push_back(cyc); ops_mdl.push_back(IO_MODEL); ops_dat.push_back(DRAM16_data);
        pend_m = IO_MODEL; pend_d = DRAM16_data; cd = lat;
      end
      if (res_done_cyc >= 0 && cyc >= res_done_cyc + 2) break;
      @(negedge clk);
    end
    WT_DONE = 1'b0; RD_DONE = 1'b0;
  endtask

  // Reference: the request list is the write burst (if mode bit 0) followed by
  // the read burst (if mode bit 1), word k = seed + k; errors are the read
  // indices the controller corrupted, saturating at all-ones.
  task automatic check_ref(input string tag, input logic [1:0] m, input logic [7:0] n,
                           input logic [15:0] s, input int lat, input logic [7:0] bad,
                           input bit tmo_run);
    logic [1:0]  em[$];
    logic [15:0] ed[$];
    int e_err, nlim, last;
    e_err = 0;
    if (m != 2'b00 && n != 8'd0) begin
      for (int p = 0; p < 2; p++) begin
        if (m[p]) begin
          for (int k = 0; k < int'(n); k++) begin
            em.push_back(p == 0 ? 2'b01 : 2'b10);
            ed.push_back(s + 16'(k));
            if (p == 1 && k < 8 && bad[k]) e_err++;
          end
        end
      end
    end
    if (e_err > 255) e_err = 255;
    chk({tag, "_done_pulses"}, res_ndone, 1);
    chk({tag, "_busy"}, res_bad_busy, 0);
    chk({tag, "_data_hold"}, res_bad_hold, 0);
    if (tmo_run) return;
    chk({tag, "_n_ops"}, ops_mdl.size(), em.size());
    chk({tag, "_err_cnt"}, res_err, e_err);
    chk({tag, "_timeout"}, res_tmo, 0);
    nlim = (ops_mdl.size() < em.size()) ? ops_mdl.size() : em.size();
    for (int i = 0; i < nlim; i++) begin
      chk($sformatf("%s_op%0d_model", tag, i), ops_mdl[i], em[i]);
      chk($sformatf("%s_op%0d_data", tag, i), ops_dat[i], ed[i]);
      if (lat == 1 && i > 0) chk($sformatf("%s_op%0d_period", tag, i), ops_cyc[i] - ops_cyc[i-1], 2 + GAP);
    end
    if (em.size() == 0) begin
      chk({tag, "_noop_done_cyc"}, res_done_cyc, 1);
    end else if (ops_cyc.size() > 0) begin
      chk({tag, "_first_io_lat"}, ops_cyc[0], 1);
      last = ops_cyc[ops_cyc.size()-1];
      chk({tag, "_done_cyc"}, res_done_cyc, last + lat + GAP + 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int nevt;
    rst_n = 1'b0; start = 1'b0; mode = '0; num_words = '0; seed = '0;
    WT_DONE = 1'b0; RD_DONE = 1'b0; RD_DATA = '0;

    vecs[0] = '{2'b01, 8'd4, 16'hA5A5, 3, 8'h00, 4, 0, 16'hA5A5};
    vecs[1] = '{2'b10, 8'd2, 16'h0010, 1, 8'h02, 2, 1, 16'h0010};
    vecs[2] = '{2'b11, 8'd3, 16'hFFFF, 1, 8'h00, 6, 0, 16'hFFFF};
    vecs[3] = '{2'b00, 8'd5, 16'h1234, 1, 8'h00, 0, 0, 16'h0000};
    vecs[4] = '{2'b01, 8'd0, 16'h1234, 1, 8'h00, 0, 0, 16'h0000};
    vecs[5] = '{2'b10, 8'd8, 16'h0000, 2, 8'hFF, 8, 8, 16'h0000};
    vecs[6] = '{2'b11, 8'd2, 16'h7FFF, 4, 8'h01, 4, 1, 16'h7FFF};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_io_en", IO_EN, 0);
    chk("rst_io_model", IO_MODEL, 0);
    chk("rst_data", DRAM16_data, 0);
    chk("rst_flags", {timeout, proto_err, err_cnt}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].mode, vecs[i].nw, vecs[i].seed, vecs[i].lat, vecs[i].bad, 1'b0, 0, 400);
      chk($sformatf("tbl%0d_ops", i), ops_mdl.size(), vecs[i].exp_ops);
      chk($sformatf("tbl%0d_err", i), res_err, vecs[i].exp_err);
      if (ops_dat.size() > 0) chk($sformatf("tbl%0d_first", i), ops_dat[0], vecs[i].exp_first);
      check_ref($sformatf("tbl%0d", i), vecs[i].mode, vecs[i].nw, vecs[i].seed, vecs[i].lat, vecs[i].bad, 1'b0);
      chk($sformatf("tbl%0d_idle_model", i), IO_MODEL, 0);
    end

    // Watchdog: controller never answers.
    run_cmd(2'b01, 8'd2, 16'h4000, 0, 8'h00, 1'b0, 0, TMO + 40);
    check_ref("tmo", 2'b01, 8'd2, 16'h4000, 0, 8'h00, 1'b1);
    chk("tmo_ops", ops_cyc.size(), 1);
    chk("tmo_flag", res_tmo, 1);
    if (ops_cyc.size() > 0) chk("tmo_latency", res_done_cyc - ops_cyc[0], TMO);
    chk("tmo_sticky", timeout, 1);
    run_cmd(2'b00, 8'd1, 16'h0000, 1, 8'h00, 1'b0, 0, 50);
    chk("tmo_cleared", res_tmo, 0);

    // Unexpected RD_DONE during a write wait; burst still completes.
    run_cmd(2'b01, 8'd3, 16'h1111, 3, 8'h00, 1'b1, 0, 200);
    check_ref("perr", 2'b01, 8'd3, 16'h1111, 3, 8'h00, 1'b0);
    chk("perr_set", res_perr, 1);
    run_cmd(2'b00, 8'd0, 16'h0000, 1, 8'h00, 1'b0, 0, 50);
    chk("perr_cleared", res_perr, 0);
    WT_DONE = 1'b1;
    @(negedge clk);
    WT_DONE = 1'b0;
    chk("perr_idle_done", proto_err, 1);
    chk("perr_idle_busy", {busy, IO_EN}, 0);

    // Asynchronous reset after the first word of a burst.
    run_cmd(2'b01, 8'd4, 16'h2222, 1, 8'h00, 1'b0, 1, 200);
    chk("abort_reached", res_aborted, 1);
    chk("abort_before_io_model", IO_MODEL == 2'b00, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_io", {IO_EN, IO_MODEL}, 0);
    chk("abort_data", DRAM16_data, 0);
    chk("abort_flags", {done, timeout, proto_err, err_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nevt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || IO_EN || busy) nevt++;
    end
    chk("abort_no_done", nevt, 0);
    run_cmd(2'b01, 8'd0, 16'h5555, 1, 8'h00, 1'b0, 0, 50);
    check_ref("post_abort", 2'b01, 8'd0, 16'h5555, 1, 8'h00, 1'b0);

    // Randomized commands against the reference.
    for (int r = 0; r < 25; r++) begin
      logic [1:0]  rm;
      logic [7:0]  rn, rb;
      logic [15:0] rs;
      int          rl;
      rm = 2'($urandom_range(0, 3));
      rn = 8'($urandom_range(0, 6));
      rs = 16'($urandom);
      rb = 8'($urandom);
      rl = $urandom_range(1, 4);
      run_cmd(rm, rn, rs, rl, rb, 1'b0, 0, 400);
      check_ref($sformatf("rnd%0d", r), rm, rn, rs, rl, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
